// File: rtl/link_game_control_pkg.sv
// Shared encodings for the player-character sequencing FSM, also used by the
// collision detector and map drawer.
package link_game_control_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_REG   = 3'd2,
    S_CHECK = 3'd3,
    S_APPLY = 3'd4,
    S_DMAP  = 3'd5,
    S_DLINK = 3'd6
  } state_e;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef struct packed {
    logic init;
    logic idle;
    logic reg_action;
    logic collide_check;
    logic apply_action;
    logic draw_map;
    logic draw;
    logic vga_sel;
  } strobes_t;

  // One strobe per state; the VGA write port belongs to the character block only while it draws.
  function automatic strobes_t decode_state(state_e s);
    strobes_t st;
    st = '0;
    case (s)
      S_INIT:  st.init          = ON;
      S_IDLE:  st.idle          = ON;
      S_REG:   st.reg_action    = ON;
      S_CHECK: st.collide_check = ON;
      S_APPLY: st.apply_action  = ON;
      S_DMAP:  st.draw_map      = ON;
      S_DLINK: begin
        st.draw    = ON;
        st.vga_sel = ON;
      end
      default: st.init = ON;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/link_game_control_frame_tick_gen.sv
// Free-running frame counter; tick_o is high during the last cycle of each frame,
// i.e. on the clock edge where the counter wraps to zero.
module frame_tick_gen #(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned CNT_W        = 20
) (
  input  logic clock,
  input  logic reset,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/link_game_control.sv
// Top-level sequencer for the player character: paces one update per frame and
// emits registered one-hot strobes for init/idle/reg/check/apply/map-draw/char-draw.
module link_game_control
  import link_game_control_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned COLLIDE_WAIT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic map_draw_done,
  input  logic draw_done,
  output logic init,
  output logic idle,
  output logic reg_action,
  output logic collide_check,
  output logic apply_action,
  output logic draw_map,
  output logic draw,
  output logic vga_sel,
  output logic frame_overrun
);

  localparam int unsigned WAIT_W = (COLLIDE_WAIT > 1) ? $clog2(COLLIDE_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(COLLIDE_WAIT - 1);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  strobes_t          strb_q;
  logic              overrun_q;
  logic              frame_tick;
  logic              consume;

  frame_tick_gen #(
    .FRAME_CYCLES(FRAME_CYCLES),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick_o(frame_tick)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    consume = OFF;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (restart) begin
          state_d = S_INIT;
        end else if (pending_q) begin
          state_d = S_REG;
          consume = ON;
        end
      end
      S_REG: begin
        state_d = S_CHECK;
        wait_d  = '0;
      end
      S_CHECK: begin
        if (wait_q == WAIT_LAST) state_d = S_APPLY;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      S_APPLY: state_d = S_DMAP;
      S_DMAP:  if (map_draw_done) state_d = S_DLINK;
      S_DLINK: if (draw_done)     state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
    // A tick landing on the consuming cycle re-arms pending: set wins over clear.
    pending_d = (pending_q & ~consume) | frame_tick;
  end

  // Strobes are registered from state_d so they line up with state_q without decode glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_INIT;
      pending_q <= OFF;
      wait_q    <= '0;
      strb_q    <= decode_state(S_INIT);
      overrun_q <= OFF;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
      strb_q    <= decode_state(state_d);
      overrun_q <= frame_tick & pending_q;
    end
  end

  assign init          = strb_q.init;
  assign idle          = strb_q.idle;
  assign reg_action    = strb_q.reg_action;
  assign collide_check = strb_q.collide_check;
  assign apply_action  = strb_q.apply_action;
  assign draw_map      = strb_q.draw_map;
  assign draw          = strb_q.draw;
  assign vga_sel       = strb_q.vga_sel;
  assign frame_overrun = overrun_q;

endmodule
